// File: rtl/fir_pkg.sv
// fir_pkg: shared state type, widths and address helper for the multi-channel FIR sequencer
package fir_pkg;
  localparam int CHANNELS = 4;
  localparam int TAPS = 8;
  localparam int CH_W = $clog2(CHANNELS);
  localparam int TAP_W = $clog2(TAPS);
  typedef enum logic [1:0] {INIT, FLUSH, IDLE, RUN} state_t;
  function automatic int unsigned ram_addr(int unsigned ch, int unsigned slot, int unsigned tap_w);
    return (ch << tap_w) | slot;
  endfunction
endpackage

// File: rtl/fir_mc_sequencer.sv
// fir_mc_sequencer: FIR control for interleaved channels, each with its own circular delay line
module fir_mc_sequencer
  import fir_pkg::*;
#(
  parameter int CHANNELS = 1 << CH_W,
  parameter int TAPS = 1 << TAP_W,
  localparam int CW = $clog2(CHANNELS),
  localparam int TW = $clog2(TAPS)
) (
  input  logic clock,
  input  logic reset,
  input  logic valid_in,
  input  logic [CW-1:0] ch_in,
  input  logic flush,
  output logic ready,
  output logic [TW-1:0] rom_address,
  output logic [CW+TW-1:0] ram_address,
  output logic en,
  output logic we,
  output logic zero,
  output logic mac_init,
  output logic [CW-1:0] ch_out,
  output logic done
);
  state_t state;
  logic [TW-1:0] k;
  logic [TW-1:0] slot;
  logic [CW+TW-1:0] f;
  logic [TW-1:0] wp [CHANNELS];
  logic run;
  logic tap0;
  // tap k reads the sample written k samples ago on the latched channel
  always_comb begin
    run = state == RUN;
    tap0 = run && k == '0;
    slot = wp[ch_out] - k;
    ready = state == IDLE;
    en = run || state == FLUSH;
    we = tap0 || state == FLUSH;
    zero = state == FLUSH;
    mac_init = tap0;
    rom_address = run ? k : '0;
    ram_address = state == FLUSH ? f : run ? (CW+TW)'(ram_addr(32'(ch_out), 32'(slot), TW)) : '0;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= INIT;
      k <= '0;
      f <= '0;
      ch_out <= '0;
      done <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) wp[i] <= '0;
    end else begin
      done <= run && &k;
      case (state)
        INIT: state <= FLUSH;
        FLUSH: begin
          f <= f + 1'b1;
          if (&f) begin
            state <= IDLE;
            for (int i = 0; i < CHANNELS; i++) wp[i] <= '0;
          end
        end
        IDLE:
          if (flush) state <= FLUSH;
          else if (valid_in) begin
            ch_out <= ch_in;
            k <= '0;
            state <= RUN;
          end
        default: begin
          k <= k + 1'b1;
          if (&k) begin
            wp[ch_out] <= wp[ch_out] + 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_fir_mc_sequencer.sv
// tb_fir_mc_sequencer: scoreboard bench for the multi-channel FIR sequencer (4 channels, 8 taps)
module tb_fir_mc_sequencer;
  localparam int CH = 4;
  localparam int TP = 8;
  typedef struct packed {logic [4:0] ram; logic [2:0] rom; logic we; logic mac;} exp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic valid_in = 1'b0;
  logic flush = 1'b0;
  logic [1:0] ch_in = '0;
  logic ready, en, we, zero, mac_init, done;
  logic [2:0] rom_address;
  logic [4:0] ram_address;
  logic [1:0] ch_out;
  int vectors = 0;
  int miscompares = 0;
  logic [2:0] wp_m [CH];
  exp_t sb[$];
  always #5 clock = ~clock;
  fir_mc_sequencer #(.CHANNELS(CH), .TAPS(TP)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ch_in(ch_in), .flush(flush),
    .ready(ready), .rom_address(rom_address), .ram_address(ram_address), .en(en), .we(we),
    .zero(zero), .mac_init(mac_init), .ch_out(ch_out), .done(done)
  );
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic check_init_flush();
    #1;
    vectors++;
    if ({ready, en, we, zero, mac_init, done, rom_address, ram_address} !== '0) begin
      miscompares++;
      $display("FAIL init: got rdy=%b en=%b we=%b z=%b mi=%b d=%b rom=%0d ram=%0d, want all 0",
               ready, en, we, zero, mac_init, done, rom_address, ram_address);
    end
    for (int i = 0; i < CH * TP; i++) begin
      @(negedge clock);
      vectors++;
      if ({en, we, zero, ready, mac_init} !== 5'b11100 || ram_address !== 5'(i)) begin
        miscompares++;
        $display("FAIL flush[%0d]: got en=%b we=%b z=%b rdy=%b mi=%b ram=%0d, want 1 1 1 0 0 ram=%0d",
                 i, en, we, zero, ready, mac_init, ram_address, i);
      end
    end
    @(negedge clock);
    vectors++;
    if ({ready, en, we, zero, mac_init, done} !== 6'b100000) begin
      miscompares++;
      $display("FAIL idle_after_flush: got rdy=%b en=%b we=%b z=%b mi=%b d=%b, want 1 0 0 0 0 0",
               ready, en, we, zero, mac_init, done);
    end
    for (int c = 0; c < CH; c++) wp_m[c] = '0;
  endtask
  task automatic send(input logic [1:0] c);
    exp_t e;
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (!ready) begin
      miscompares++;
      $display("FAIL ready_timeout: got ready=%b, want 1 within 100 cycles", ready);
    end
    valid_in = 1'b1;
    ch_in = c;
    for (int k = 0; k < TP; k++) sb.push_back('{ram: {c, 3'(wp_m[c] - k)}, rom: 3'(k), we: k == 0, mac: k == 0});
    @(posedge clock);
    #1 valid_in = 1'b0;
    for (int k = 0; k < TP; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      vectors++;
      if ({ram_address, rom_address, we, mac_init} !== e || !en || ready || zero || done || ch_out !== c) begin
        miscompares++;
        $display("FAIL tap ch%0d k%0d: got ram=%0d rom=%0d we=%b mi=%b en=%b rdy=%b z=%b d=%b cho=%0d, want ram=%0d rom=%0d we=%b mi=%b en=1 rdy=0 z=0 d=0 cho=%0d",
                 c, k, ram_address, rom_address, we, mac_init, en, ready, zero, done, ch_out, e.ram, e.rom, e.we, e.mac, c);
      end
    end
    wp_m[c] = wp_m[c] + 3'd1;
    @(negedge clock);
    vectors++;
    if (!done || !ready || en || ch_out !== c) begin
      miscompares++;
      $display("FAIL done ch%0d: got d=%b rdy=%b en=%b cho=%0d, want d=1 rdy=1 en=0 cho=%0d", c, done, ready, en, ch_out, c);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clock);
    #1;
    vectors++;
    if ({ready, en, we, zero, mac_init, done, ch_out, rom_address, ram_address} !== '0) begin
      miscompares++;
      $display("FAIL in_reset: got rdy=%b en=%b we=%b z=%b d=%b cho=%0d ram=%0d, want all 0",
               ready, en, we, zero, done, ch_out, ram_address);
    end
    @(negedge clock);
    reset = 1'b1;
    check_init_flush();
  endtask
  task automatic test_single();
    send(2'd2);
    @(negedge clock);
    vectors++;
    if (done !== 1'b0 || ch_out !== 2'd2) begin
      miscompares++;
      $display("FAIL done_pulse: got d=%b cho=%0d, want d=0 cho=2", done, ch_out);
    end
  endtask
  task automatic test_wrap();
    for (int i = 0; i < TP; i++) send(2'd2);
  endtask
  task automatic test_interleave();
    send(2'd0);
    send(2'd3);
    send(2'd0);
    send(2'd1);
  endtask
  task automatic test_back_to_back();
    int acc;
    acc = 0;
    valid_in = 1'b1;
    ch_in = 2'd1;
    for (int i = 0; i < 3 * (TP + 1); i++) begin
      if (ready) acc++;
      @(negedge clock);
    end
    valid_in = 1'b0;
    wp_m[1] = wp_m[1] + 3'd3;
    vectors++;
    if (acc != 3 || !done) begin
      miscompares++;
      $display("FAIL back_to_back: got %0d accepts done=%b, want 3 accepts done=1", acc, done);
    end
    valid_in = 1'b1;
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    vectors++;
    if (!zero || ready || ram_address !== 5'd0 || mac_init) begin
      miscompares++;
      $display("FAIL flush_priority: got z=%b rdy=%b ram=%0d mi=%b, want z=1 rdy=0 ram=0 mi=0", zero, ready, ram_address, mac_init);
    end
    repeat (CH * TP - 1) @(negedge clock);
    for (int c = 0; c < CH; c++) wp_m[c] = '0;
    send(2'd1);
  endtask
  task automatic test_reset_mid_run();
    send(2'd3);
    send(2'd3);
    valid_in = 1'b1;
    ch_in = 2'd3;
    @(posedge clock);
    #1 valid_in = 1'b0;
    repeat (4) @(negedge clock);
    vectors++;
    if (rom_address !== 3'd3 || ram_address !== 5'd31) begin
      miscompares++;
      $display("FAIL run4: got rom=%0d ram=%0d, want rom=3 ram=31", rom_address, ram_address);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({ready, en, we, zero, mac_init, done, ch_out, rom_address, ram_address} !== '0) begin
      miscompares++;
      $display("FAIL abort: got rdy=%b en=%b we=%b z=%b d=%b cho=%0d ram=%0d, want all 0",
               ready, en, we, zero, done, ch_out, ram_address);
    end
    @(negedge clock);
    reset = 1'b1;
    check_init_flush();
    send(2'd3);
    send(2'd2);
  endtask
  initial begin
    for (int c = 0; c < CH; c++) wp_m[c] = '0;
    test_reset();
    test_single();
    test_wrap();
    test_interleave();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
